// File: rtl/visuaudio_pkg.sv
// rtl/visuaudio_pkg.sv - shared types and helpers for the spectrum band aggregator
package visuaudio_pkg;

  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } band_state_t;

  localparam int N_BANDS_DEF = 16;
  localparam int MAG_W       = 16;

  typedef logic [15:0][15:0] band_vec_t;

  function automatic logic [MAG_W-1:0] sat_add(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    logic [MAG_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[MAG_W] ? '1 : s[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/cplx_mag_approx.sv
// rtl/cplx_mag_approx.sv - combinational |re|+|im| magnitude with 16-bit saturation
module cplx_mag_approx
  import visuaudio_pkg::*;
(
  input  logic [MAG_W-1:0] re,
  input  logic [MAG_W-1:0] im,
  output logic [MAG_W-1:0] mag
);

  logic [MAG_W:0] abs_re;
  logic [MAG_W:0] abs_im;
  logic [MAG_W:0] sum;

  // Absolute values are taken in 17 bits so |-32768| = 32768 is representable.
  always_comb begin
    abs_re = re[MAG_W-1] ? (~{re[MAG_W-1], re} + 17'd1) : {1'b0, re};
    abs_im = im[MAG_W-1] ? (~{im[MAG_W-1], im} + 17'd1) : {1'b0, im};
    sum    = abs_re + abs_im;
    mag    = sum[MAG_W] ? '1 : sum[MAG_W-1:0];
  end

endmodule

// File: rtl/spectrum_band_aggregator.sv
// rtl/spectrum_band_aggregator.sv - bins-to-bands summation with peak-hold and linear decay
module spectrum_band_aggregator
  import visuaudio_pkg::*;
#(
  parameter int               N_BANDS       = N_BANDS_DEF,
  parameter int               BINS_PER_BAND = 4,
  parameter logic [MAG_W-1:0] DECAY         = 16'd256
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_bin_valid,
  output logic                          o_bin_ready,
  input  logic [MAG_W-1:0]              i_bin_re,
  input  logic [MAG_W-1:0]              i_bin_im,
  input  logic                          i_bin_last,
  output logic [N_BANDS-1:0][MAG_W-1:0] o_band_data,
  output logic                          o_done
);

  localparam int N_BINS = N_BANDS * BINS_PER_BAND;
  localparam int CNT_W  = $clog2(N_BINS + 1);
  localparam int SHIFT  = $clog2(BINS_PER_BAND);
  localparam int IDX_W  = $clog2(N_BANDS);

  band_state_t                   state_q, state_d;
  logic [CNT_W-1:0]              bin_cnt;
  logic [CNT_W-1:0]              band_sel;
  logic [IDX_W-1:0]              upd_idx;
  logic [N_BANDS-1:0][MAG_W-1:0] acc;
  logic [MAG_W-1:0]              mag;
  logic [MAG_W-1:0]              decayed;
  logic                          xfer;
  logic                          in_range;

  cplx_mag_approx u_mag (
    .re  (i_bin_re),
    .im  (i_bin_im),
    .mag (mag)
  );

  assign xfer     = i_bin_valid && o_bin_ready;
  assign in_range = bin_cnt < CNT_W'(N_BINS);
  assign band_sel = bin_cnt >> SHIFT;
  assign decayed  = (o_band_data[upd_idx] > DECAY) ? (o_band_data[upd_idx] - DECAY) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCUM:  if (xfer && i_bin_last) state_d = S_UPDATE;
      S_UPDATE: if (upd_idx == IDX_W'(N_BANDS - 1)) state_d = S_DONE;
      S_DONE:   state_d = S_ACCUM;
      default:  state_d = S_ACCUM;
    endcase
  end

  always_comb begin
    o_bin_ready = (state_q == S_ACCUM);
    o_done      = (state_q == S_DONE);
  end

  // Bins past the last band are still accepted; the counter parks at N_BINS so it never wraps into band 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_cnt     <= '0;
      upd_idx     <= '0;
      acc         <= '0;
      o_band_data <= '0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (xfer) begin
            for (int b = 0; b < N_BANDS; b++) begin
              if (in_range && band_sel == CNT_W'(b)) acc[b] <= sat_add(acc[b], mag);
            end
            if (in_range) bin_cnt <= bin_cnt + CNT_W'(1);
          end
          upd_idx <= '0;
        end
        S_UPDATE: begin
          o_band_data[upd_idx] <= (acc[upd_idx] > decayed) ? acc[upd_idx] : decayed;
          acc[upd_idx]         <= '0;
          upd_idx              <= upd_idx + IDX_W'(1);
        end
        S_DONE: bin_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_band_aggregator.sv
// tb/tb_spectrum_band_aggregator.sv - directed self-checking bench for spectrum_band_aggregator
module tb_spectrum_band_aggregator;
  import visuaudio_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            bin_valid;
  logic            bin_ready;
  logic [15:0]     bin_re;
  logic [15:0]     bin_im;
  logic            bin_last;
  logic [15:0][15:0] band_data;
  logic            done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spectrum_band_aggregator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bin_valid (bin_valid),
    .o_bin_ready (bin_ready),
    .i_bin_re    (bin_re),
    .i_bin_im    (bin_im),
    .i_bin_last  (bin_last),
    .o_band_data (band_data),
    .o_done      (done)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic band_vec_t fill(input logic [15:0] v);
    band_vec_t r;
    for (int i = 0; i < 16; i++) r[i] = v;
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge after the transfer edge.
  task automatic send_bin(input logic [15:0] re, input logic [15:0] im, input logic last,
                          output int waited);
    bin_valid = 1'b1;
    bin_re    = re;
    bin_im    = im;
    bin_last  = last;
    waited    = 0;
    while (bin_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) chk("ready_timeout", 1'b0, 1'b1);
    @(negedge clk);
    bin_valid = 1'b0;
    bin_last  = 1'b0;
  endtask

  task automatic check_sweep(input string tag);
    int c;
    int low;
    c   = 0;
    low = 0;
    while (done !== 1'b1 && c < 40) begin
      if (bin_ready === 1'b0) low++;
      @(negedge clk);
      c++;
    end
    if (bin_ready === 1'b0) low++;
    chk({tag, "_done_latency"}, c + 1, 17);
    chk({tag, "_ready_low"}, low, 17);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_ready_back"}, bin_ready, 1'b1);
  endtask

  task automatic send_const(input int n, input logic [15:0] re, input logic [15:0] im,
                            input string tag);
    int w;
    for (int i = 0; i < n; i++) send_bin(re, im, i == n - 1, w);
    check_sweep(tag);
  endtask

  initial begin
    band_vec_t exp;
    int        w;

    rst       = 1'b1;
    bin_valid = 1'b0;
    bin_re    = '0;
    bin_im    = '0;
    bin_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_bands", band_data, '0);
    chk("reset_done", done, 1'b0);
    chk("reset_ready", bin_ready, 1'b1);

    send_const(64, 16'd100, -16'sd50, "f64");
    chk("f64_bands", band_data, fill(16'd600));

    send_const(64, 16'd0, 16'd0, "dec1");
    chk("decay_344", band_data, fill(16'd344));
    send_const(64, 16'd0, 16'd0, "dec2");
    chk("decay_88", band_data, fill(16'd88));
    send_const(64, 16'd0, 16'd0, "dec3");
    chk("decay_floor", band_data, fill(16'd0));

    for (int i = 0; i < 10; i++) send_bin(16'(10 * (i + 1)), 16'd0, i == 9, w);
    check_sweep("short");
    exp    = fill(16'd0);
    exp[0] = 16'd100;
    exp[1] = 16'd260;
    exp[2] = 16'd190;
    chk("short_bands", band_data, exp);

    for (int i = 0; i < 70; i++) begin
      if (i < 64) send_bin(16'd1000, 16'd1000, 1'b0, w);
      else        send_bin(16'h8000, 16'd0, i == 69, w);
    end
    check_sweep("long");
    chk("long_bands", band_data, fill(16'd8000));

    for (int i = 0; i < 64; i++) begin
      if (i < 4)      send_bin(16'h8000, 16'h8000, 1'b0, w);
      else if (i < 8) send_bin(16'd20000, 16'd0, 1'b0, w);
      else            send_bin(16'd0, 16'd0, i == 63, w);
    end
    check_sweep("sat");
    exp    = fill(16'd7744);
    exp[0] = 16'hFFFF;
    exp[1] = 16'hFFFF;
    chk("sat_bands", band_data, exp);

    for (int i = 0; i < 64; i++) send_bin(16'd100, -16'sd50, i == 63, w);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bands", band_data, '0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ready", bin_ready, 1'b1);
    rst = 1'b0;

    send_const(64, 16'd100, -16'sd50, "post_rst");
    chk("post_rst_bands", band_data, fill(16'd600));

    for (int i = 0; i < 64; i++) send_bin(16'd0, 16'd0, i == 63, w);
    send_bin(16'd1000, 16'd0, 1'b0, w);
    chk("bp_wait", w, 17);
    chk("bp_prev_bands", band_data, fill(16'd344));
    for (int i = 1; i < 64; i++) send_bin(16'd0, 16'd0, i == 63, w);
    check_sweep("bp");
    exp    = fill(16'd88);
    exp[0] = 16'd1000;
    chk("bp_bands", band_data, exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spectrum_band_aggregator.md
# spectrum_band_aggregator

Collects the streaming complex FFT output of one frame, converts each bin to an approximate magnitude, and sums consecutive bins into 16 frequency bands. Each band then passes through a peak-hold with linear decay. It sits directly upstream of the renderer: `o_band_data` feeds the renderer's 16×16-bit FFT data input and `o_done` feeds its done input. Only the band registers are visible downstream, and they change only during the update sweep.

## Interface
- `N_BANDS`, default 16: number of output bands; fixed at 16 by the renderer's input width.
- `BINS_PER_BAND`, default 4: consecutive bins summed per band; must be a power of two.
- `DECAY`, default 16'd256: amount each held band value falls per frame.

Ports:
- `i_clk`, in, 1: the single clock for the block.
- `i_rst`, in, 1: reset; synchronous and active-high.
- `i_bin_valid`, in, 1: the bin on `i_bin_re`/`i_bin_im` is valid this cycle.
- `o_bin_ready`, out, 1: block can accept a bin; a bin transfers when valid && ready.
- `i_bin_re`, in, 16: real part, two's complement.
- `i_bin_im`, in, 16: imaginary part, two's complement.
- `i_bin_last`, in, 1: marks the final bin of the frame; qualified by the transfer.
- `o_band_data`, out, [N_BANDS-1:0][15:0]: held band magnitudes, unsigned.
- `o_done`, out, 1: one-cycle pulse; all band values are updated and stable.

## Operation
- States are S_ACCUM, S_UPDATE and S_DONE; reset enters S_ACCUM.
- **S_ACCUM** (`o_bin_ready`=1):
  - Each transfer computes mag = |re| + |im|. |−32768| = 32768; the 17-bit sum saturates to 16'hFFFF.
  - The bin goes to band `bin_cnt / BINS_PER_BAND`, and `acc[band]` is incremented with a saturating 16-bit add.
  - `bin_cnt` increments on every transfer.
  - Bins with `bin_cnt >= N_BANDS*BINS_PER_BAND` are accepted and discarded; the counter saturates and does not wrap.
  - A transfer with `i_bin_last`=1 is accumulated or discarded by the same rule, then the state goes to S_UPDATE with `upd_idx`=0.
- **S_UPDATE** (`o_bin_ready`=0), running for N_BANDS cycles. On the cycle with `upd_idx`=k:
  - `decayed` = `o_band_data[k]` − DECAY, floored at 0.
  - `o_band_data[k]` ← max(`acc[k]`, `decayed`).
  - `acc[k]` ← 0.
  - When k = N_BANDS−1, go to S_DONE.
- **S_DONE** (`o_bin_ready`=0): `o_done`=1 for exactly this cycle; `bin_cnt` ← 0; next state S_ACCUM.
- A short frame (`i_bin_last` before bin 63) leaves the unreached accumulators at 0, so those bands only decay.
- Reset mid-frame or mid-sweep: every accumulator, every band, `bin_cnt`, `upd_idx` and `o_done` go to 0; the state goes to S_ACCUM. The partial frame is lost.

## Timing
- Reset values: `o_band_data` = 0, `o_done` = 0, `o_bin_ready` = 1.
- The magnitude is combinational. It is registered into `acc` on the transfer edge, so there are no bubbles and one bin per cycle is accepted in S_ACCUM.
- The transfer with `i_bin_last` at edge T:
  - `o_bin_ready` is 0 from T+1 through T+N_BANDS+1.
  - Band k is written at edge T+1+k.
  - `o_done` is high during the cycle after edge T+N_BANDS, i.e. 17 cycles after the last bin.
  - `o_bin_ready` is 1 again in the following cycle.
- `o_bin_ready` depends only on the state, never combinationally on `i_bin_valid`.
- A bin presented while ready=0 must be held by the producer; it is not lost.
- `o_band_data` changes only during S_UPDATE, so the renderer may sample it any time after `o_done`.

## Structure
- Shared package `visuaudio_pkg` holds:
  - the state enum `band_state_t`;
  - constants `N_BANDS_DEF` and `MAG_W` = 16;
  - typedef `band_vec_t` = logic [15:0][15:0].
- One sub-module, `cplx_mag_approx`: combinational |re|+|im| with saturation. It is instantiated once and unit-testable on its own.

## Test plan
- Reset, then idle: `o_band_data` all 0, `o_done`=0, `o_bin_ready`=1.
- Frame of 64 bins, all re=100, im=−50, last on bin 63: every band = 600; `o_done` fires 17 cycles after the last bin; ready is low for exactly 17 cycles.
- Decay: previous frame at 600 everywhere, then a frame of zeros: every band = 344; after a third zero frame: 88; after a fourth: 0 (floored, no wrap).
- Saturation: re=−32768, im=−32768 on all 4 bins of band 0: mag = 16'hFFFF and band 0 = 16'hFFFF. Bins of re=20000, im=0 in band 1: sum saturates at 65535.
- Short and long frames:
  - Last at bin 9 after a frame of zeros: bands 0–2 hold their sums; bands 3–15 stay 0.
  - A 70-bin frame: bins 64–69 do not change any band.
- Backpressure and reset:
  - Valid held high through the sweep: the first bin of the next frame transfers exactly on the first cycle with ready=1.
  - Reset asserted at `upd_idx`=5: all outputs 0 the next cycle, and the following frame behaves as in the 64-bin scenario.
